// File: rtl/fifo4_buffer.sv
// fifo4_buffer: 4-entry first-word-fall-through FIFO with valid/ready on both
// sides. Writes go through a one-hot 2-to-4 decode of the write pointer; reads
// come out of a two-level 2:1 mux tree driven by the read pointer.
// Optional status outputs (full, empty, almost_full) are enabled by defining
// FIFO4_STATUS_EN.
module fifo4_buffer #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic [2:0]           count
`ifdef FIFO4_STATUS_EN
    ,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full
`endif
);

    logic [3:0][DATAWIDTH-1:0] mem;
    logic [1:0]                wr_ptr;
    logic [1:0]                rd_ptr;
    logic [2:0]                cnt;
    logic [3:0]                wr_sel;
    logic [3:0]                wr_en;
    logic                      push;
    logic                      pop;
    logic [DATAWIDTH-1:0]      rd_lo;
    logic [DATAWIDTH-1:0]      rd_hi;

    // Handshakes: a full FIFO never accepts, even when popping the same cycle.
    assign wr_ready = (cnt != 3'd4);
    assign rd_valid = (cnt != 3'd0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign count    = cnt;

    // 2-to-4 decode of the write pointer into per-entry write enables.
    always_comb begin
        wr_sel = 4'b0000;
        case (wr_ptr)
            2'd0:    wr_sel = 4'b0001;
            2'd1:    wr_sel = 4'b0010;
            2'd2:    wr_sel = 4'b0100;
            default: wr_sel = 4'b1000;
        endcase
        wr_en = wr_sel & {4{push}};
    end

    // Storage: data only, no reset; stale words are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) mem[i] <= wr_data;
        end
    end

    // Read tree: first level picks within each pair, second level picks the pair.
    always_comb begin
        rd_lo   = rd_ptr[0] ? mem[1] : mem[0];
        rd_hi   = rd_ptr[0] ? mem[3] : mem[2];
        rd_data = rd_ptr[1] ? rd_hi : rd_lo;
    end

    // Pointers wrap 3->0 through natural 2-bit overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
        end
    end

    // Occupancy: moves only when exactly one side handshakes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 3'd0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef FIFO4_STATUS_EN
    // Status flags decoded straight from the occupancy count.
    always_comb begin
        full        = (cnt == 3'd4);
        empty       = (cnt == 3'd0);
        almost_full = (cnt >= 3'd3);
    end
`endif

endmodule

// File: tb/tb_fifo4_buffer.sv
// tb_fifo4_buffer: directed scenarios followed by random traffic. The reference
// model is a plain queue of accepted words, capped at four; the monitor samples
// on the falling edge, checks status and head data, then applies the
// handshake that the next rising edge will perform.
module tb_fifo4_buffer;

    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [2:0]    count;
`ifdef FIFO4_STATUS_EN
    logic          full;
    logic          empty;
    logic          almost_full;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    fifo4_buffer #(.DATAWIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count)
`ifdef FIFO4_STATUS_EN
        ,
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard/monitor: compares against the queue model, then advances it.
    initial begin
        int  sz;
        logic acc;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                chk("rst_count", 32'(count), 0);
                chk("rst_wr_ready", 32'(wr_ready), 1);
                chk("rst_rd_valid", 32'(rd_valid), 0);
            end else begin
                sz = exp_q.size();
                chk("count", 32'(count), 32'(sz));
                chk("wr_ready", 32'(wr_ready), 32'(sz != 4));
                chk("rd_valid", 32'(rd_valid), 32'(sz != 0));
`ifdef FIFO4_STATUS_EN
                chk("full", 32'(full), 32'(sz == 4));
                chk("empty", 32'(empty), 32'(sz == 0));
                chk("almost_full", 32'(almost_full), 32'(sz >= 3));
`endif
                if (sz != 0) chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
                acc = wr_valid && (sz < 4);
                if (sz != 0 && rd_ready) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(wr_data);
            end
        end
    end

    // One cycle of stimulus: inputs change 2 time units after the rising edge.
    task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic rr);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset_check(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 1);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
`ifdef FIFO4_STATUS_EN
        chk({tag, "_empty"}, 32'(empty), 1);
`endif
    endtask

    initial begin
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        reset    = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        async_reset_check("reset_idle");
        @(posedge clk);
        #2;
        reset = 1'b0;
        cyc(0, 8'h00, 0);

        // Fill to full; 0x55 held on the write side must not be stored.
        cyc(1, 8'h11, 0);
        cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 0);
        cyc(1, 8'h44, 0);
        chk("full_count", 32'(count), 4);
        chk("full_head", 32'(rd_data), 32'h11);
        cyc(1, 8'h55, 0);
        cyc(1, 8'h55, 0);
        chk("full_hold_count", 32'(count), 4);

        // Drain with wrap, then a word through entry 0 after both pointers wrap.
        repeat (4) cyc(0, 8'h00, 1);
        chk("drained_count", 32'(count), 0);
        cyc(1, 8'h66, 0);
        chk("wrap_data", 32'(rd_data), 32'h66);
        cyc(0, 8'h00, 1);

        // Simultaneous push/pop at count=2.
        cyc(1, 8'hA0, 0);
        cyc(1, 8'hA1, 0);
        cyc(1, 8'hA2, 1);
        chk("simul_count", 32'(count), 2);
        chk("simul_head", 32'(rd_data), 32'hA1);
        cyc(0, 8'h00, 1);
        chk("simul_next", 32'(rd_data), 32'hA2);
        cyc(0, 8'h00, 1);

        // Full with both sides active: pop happens, push waits one edge.
        cyc(1, 8'hB0, 0);
        cyc(1, 8'hB1, 0);
        cyc(1, 8'hB2, 0);
        cyc(1, 8'hB3, 0);
        cyc(1, 8'hEE, 1);
        chk("full_pop_count", 32'(count), 3);
        cyc(1, 8'hEE, 0);
        chk("full_refill_count", 32'(count), 4);
        repeat (4) cyc(0, 8'h00, 1);

        // Reset mid-operation with three words stored.
        cyc(1, 8'hC0, 0);
        cyc(1, 8'hC1, 0);
        cyc(1, 8'hC2, 0);
        async_reset_check("reset_mid");
        @(posedge clk);
        #2;
        reset = 1'b0;
        cyc(1, 8'h5A, 0);
        chk("post_reset_count", 32'(count), 1);
        chk("post_reset_data", 32'(rd_data), 32'h5A);
        cyc(0, 8'h00, 1);

        // Random traffic with varying pressure on each side.
        for (int i = 0; i < 400; i++) begin
            int wp = (i < 200) ? 70 : 30;
            cyc(($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < 50));
        end
        repeat (6) cyc(0, 8'h00, 1);
        chk("final_empty", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
